shift_mul_ctrl: RTL and testbench
=================================

Name: shift_mul_ctrl

Overview:
Sequential unsigned shift-add multiplier. An FSM sequences an accumulator, a multiplier/shift register and an iteration counter, one add-and-shift step per clock. Start/done handshake for a host FSM or CPU execute stage that owns the operands. Product is held until the next accepted start.

Parameters:
DATA_WIDTH, 16, operand width W in bits (>= 2); product is 2W bits
CNT_WIDTH, $clog2(DATA_WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; accepted only in IDLE or DONE
abort  input  1  cancel an operation in progress; return to IDLE, product cleared
a  input  DATA_WIDTH  multiplicand, sampled on accepted start
b  input  DATA_WIDTH  multiplier, sampled on accepted start
busy  output  1  high while in CALC
done  output  1  one-cycle pulse; product valid from this cycle on
product  output  2*DATA_WIDTH  {A,Q} result register

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): on a rst-high edge, state=IDLE, M=0, A=0, Q=0, C=0, cnt=0. Outputs busy=0, done=0, product=0. rst has priority over abort and start.
- Internal registers: M (W, multiplicand), A (W, accumulator), Q (W, multiplier/low product), C (1, carry), cnt (CNT_WIDTH).
- States: IDLE, CALC, DONE. State is registered. busy=(state==CALC). done=(state==DONE). Both are Moore outputs.
- IDLE: start=1 -> M<=a, Q<=b, A<=0, C<=0, cnt<=W, next CALC. Otherwise all registers hold.
- CALC, per cycle:
  - sum = {1'b0,A} + (Q[0] ? {1'b0,M} : 0), W+1 bits.
  - {C,A,Q} <= {1'b0, sum, Q} >> 1, i.e. A<=sum[W:1], Q<={sum[0],Q[W-1:1]}, C<=0.
  - cnt<=cnt-1.
  - If cnt==1 this cycle, next state is DONE; else stay in CALC.
- DONE: lasts exactly one cycle, then goes to IDLE. If start=1 in DONE, load exactly as in IDLE and go to CALC (back-to-back ops).
- Latency: start sampled at edge N. busy is high for cycles N+1..N+W. done is high in cycle N+W+1. Throughput is one op per W+1 cycles.
- product={A,Q}. It is stable from done until the edge that accepts the next start. It is then overwritten: A=0, Q=b. Consumers must latch the result at done.
- start while busy: ignored, no error flag. Operands are not resampled.
- abort=1 in CALC: next state IDLE, A=0, Q=0, cnt=0, done not asserted. abort in IDLE or DONE: no effect; start in the same cycle wins.
- Widths: the full 2W product never overflows. The max operand pair gives (2^W-1)^2. No signed support.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2) and the CNT_WIDTH derivation function.
- Sub-module mul_seq_fsm: state register, cnt, and decoded strobes (load, step, clear). The top holds the M/A/Q/C datapath.

Test Plan:
- W=16, rst held 2 cycles -> busy=0, done=0, product=0; start=1 with a=3, b=5 -> busy high exactly 16 cycles, done pulse on cycle 17, product=32'h0000_000F.
- a=16'hFFFF, b=16'hFFFF -> product=32'hFFFE_0001 at done. Also a=0, b=16'h1234 -> product=0, same 17-cycle latency.
- start re-asserted with a=7, b=7 during CALC of 9*9 -> ignored; product=81 at the original done cycle; no second done.
- start held high in the DONE cycle with new a=2, b=10 -> first done shows the prior product. The next op begins immediately, done after 17 more cycles with product=20.
- abort asserted at CALC cycle 5 -> IDLE next cycle, product=0, no done. Also rst asserted mid-CALC -> all outputs 0 at the next edge.
- DATA_WIDTH=4 build, exhaustive 256 operand pairs -> every product equals a*b, done exactly 5 cycles after start.

Source files
------------

// File: rtl/shift_mul_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_mul_ctrl_pkg
// Purpose  : State encodings and counter-width helper for the shift-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package shift_mul_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold the value W itself, hence W+1 codes.
    function automatic int cnt_width_f(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_mul_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_fsm
// Purpose  : Sequencer for the shift-add multiplier: state, iteration count, strobes.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_fsm
    import shift_mul_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = cnt_width_f(DATA_WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic clear
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_INIT = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= C_CNT_INIT;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (step) begin
            r_cnt <= r_cnt - C_CNT_ONE;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = start ? ST_CALC : ST_IDLE;
            ST_CALC: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == C_CNT_ONE) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_CALC;
                end
            end
            // DONE is a single-cycle state; a start here chains the next op.
            ST_DONE: w_next_state = start ? ST_CALC : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state == ST_CALC);
        done  = (r_state == ST_DONE);
        load  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
        step  = (r_state == ST_CALC) && !abort;
        clear = (r_state == ST_CALC) && abort;
    end

endmodule
`default_nettype wire

// File: rtl/shift_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_mul_ctrl
// Purpose  : Sequential unsigned shift-add multiplier, one add-and-shift per clock.
// Revision : 1.0 - initial release
// ============================================================================
module shift_mul_ctrl
    import shift_mul_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int CNT_WIDTH = cnt_width_f(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_m;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_c;
    logic [DATA_WIDTH:0]   w_sum;
    logic                  w_load;
    logic                  w_step;
    logic                  w_clear;

    mul_seq_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fsm (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .load  (w_load),
        .step  (w_step),
        .clear (w_clear)
    );

    // Carry is cleared on every shift, so {C,A} is the zero-extended accumulator.
    assign w_sum = {r_c, r_a} + (r_q[0] ? {1'b0, r_m} : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= '0;
            r_a <= '0;
            r_q <= '0;
            r_c <= 1'b0;
        end else if (w_load) begin
            r_m <= a;
            r_a <= '0;
            r_q <= b;
            r_c <= 1'b0;
        end else if (w_clear) begin
            r_a <= '0;
            r_q <= '0;
            r_c <= 1'b0;
        end else if (w_step) begin
            r_a <= w_sum[DATA_WIDTH:1];
            r_q <= {w_sum[0], r_q[DATA_WIDTH-1:1]};
            r_c <= 1'b0;
        end
    end

    assign product = {r_a, r_q};

endmodule
`default_nettype wire

// File: tb/tb_shift_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_mul_ctrl
// Purpose  : Self-checking bench for shift_mul_ctrl at W=16 and W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    logic        start4;
    logic        abort4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        busy4;
    logic        done4;
    logic [7:0]  product4;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    shift_mul_ctrl #(.DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    shift_mul_ctrl #(.DATA_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive start for one edge; returns at the negedge of the first CALC cycle.
    task automatic start16(input logic [15:0] ia, input logic [15:0] ib,
                           input logic [31:0] exp, input bit push);
        a = ia;
        b = ib;
        start = 1'b1;
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // first_lat: cycle index (1 = first cycle after the start edge) on entry.
    task automatic wait_done16(input string name, input int first_lat);
        int lat;
        int nb;
        logic [31:0] exp;
        lat = first_lat;
        nb  = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        chk($sformatf("%s_done", name), {31'b0, done}, 32'd1);
        chk($sformatf("%s_lat", name), lat, 32'd17);
        chk($sformatf("%s_busycnt", name), nb, 32'(17 - first_lat));
        chk($sformatf("%s_busy_at_done", name), {31'b0, busy}, 32'd0);
        chk($sformatf("%s_prod", name), product, exp);
    endtask

    task automatic no_done16(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        chk(name, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'd3,     16'd5,     32'h0000_000F};
        vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE_0001};
        vecs[2] = '{16'h0000,  16'h1234,  32'h0000_0000};
        vecs[3] = '{16'd9,     16'd9,     32'd81};
        vecs[4] = '{16'h0001,  16'hFFFF,  32'h0000_FFFF};
        vecs[5] = '{16'h8000,  16'h0002,  32'h0001_0000};

        rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
        start4 = 1'b0; abort4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_product", product, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            start16(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
            wait_done16($sformatf("vec%0d", i), 1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
            chk($sformatf("vec%0d_held", i), product, vecs[i].p);
        end

        // start during CALC is ignored
        start16(16'd9, 16'd9, 32'd81, 1'b1);
        repeat (2) @(negedge clk);
        a = 16'd7; b = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done16("ignore_start", 4);
        @(negedge clk);
        no_done16("ignore_no_second_done", 20);
        chk("ignore_held", product, 32'd81);

        // back-to-back: start in the DONE cycle
        start16(16'd6, 16'd7, 32'd42, 1'b1);
        wait_done16("b2b_first", 1);
        start16(16'd2, 16'd10, 32'd20, 1'b1);
        wait_done16("b2b_second", 1);
        @(negedge clk);

        // abort at CALC cycle 5
        start16(16'd9, 16'd9, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_product", product, 32'd0);
        no_done16("abort_no_done", 20);
        start16(16'd3, 16'd5, 32'd15, 1'b1);
        wait_done16("after_abort", 1);
        @(negedge clk);

        // reset mid-CALC
        start16(16'd5, 16'd5, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_product", product, 32'd0);
        @(negedge clk);

        // W=4 exhaustive
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                int lat;
                a4 = 4'(ia);
                b4 = 4'(ib);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                lat = 1;
                while (!done4 && lat < 12) begin
                    @(negedge clk);
                    lat++;
                end
                chk($sformatf("w4_lat_%0d_%0d", ia, ib), lat, 32'd5);
                chk($sformatf("w4_prod_%0d_%0d", ia, ib), {24'b0, product4}, 32'(ia * ib));
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
